// File: rtl/lsu_writeback.sv
// Memory/writeback stage: runs the data-memory handshake for loads and stores,
// aligns/extends load data and is the single writer of the register file port.
module lsu_writeback #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd_addr,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_en,
  output logic [4:0]  rf_rd_addr,
  output logic [31:0] rf_data,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {StIdle, StMem, StWb} state_e;

  localparam logic [1:0] KindAlu   = 2'b00;
  localparam logic [1:0] KindLoad  = 2'b01;
  localparam logic [1:0] KindStore = 2'b10;
  localparam logic [7:0] LastCnt   = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic        live_q;
  logic [1:0]  kind_q, kind_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misalign_q, misalign_d;
  logic        timeout_q, timeout_d;

  logic        accept;
  logic        legal;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Legality and alignment of the incoming access, judged on the raw inputs.
  always_comb begin
    legal = 1'b0;
    if (in_kind == KindLoad) begin
      legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010) ||
              (in_funct3 == 3'b100) || (in_funct3 == 3'b101);
    end else if (in_kind == KindStore) begin
      legal = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
    end
    if (in_funct3[1:0] == 2'b01 && in_result[0] != 1'b0) legal = 1'b0;
    if (in_funct3[1:0] == 2'b10 && in_result[1:0] != 2'b00) legal = 1'b0;
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    load_byte = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    load_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (f3_q[1:0])
      2'b00:   load_data = {{24{load_byte[7] & ~f3_q[2]}}, load_byte};
      2'b01:   load_data = {{16{load_half[15] & ~f3_q[2]}}, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state: capture on accept, memory wait with timeout, one-cycle writeback.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wb_data_d  = wb_data_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    accept     = in_valid & in_ready;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          kind_d  = in_kind;
          f3_d    = in_funct3;
          rd_d    = in_rd_addr;
          addr_d  = in_result;
          sdata_d = in_store_data;
          cnt_d   = 8'd0;
          if (in_kind == KindAlu) begin
            wb_data_d = in_result;
            state_d   = StWb;
          end else if (in_kind == KindLoad || in_kind == KindStore) begin
            if (legal) state_d = StMem;
            else       misalign_d = 1'b1;
          end
        end
      end
      StMem: begin
        // An ack in the limit cycle takes priority over the timeout.
        if (mem_ack) begin
          if (kind_q == KindLoad) begin
            wb_data_d = load_data;
            state_d   = StWb;
          end else begin
            state_d = StIdle;
          end
        end else if (cnt_q == LastCnt) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and captured-operand registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      live_q     <= 1'b0;
      kind_q     <= 2'b00;
      f3_q       <= 3'b000;
      rd_q       <= 5'd0;
      addr_q     <= 32'd0;
      sdata_q    <= 32'd0;
      wb_data_q  <= 32'd0;
      cnt_q      <= 8'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_q     <= 1'b1;
      kind_q     <= kind_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wb_data_q  <= wb_data_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs decoded from state and registered operands only.
  always_comb begin
    // live_q keeps in_ready low for every cycle spent in reset.
    in_ready     = (state_q == StIdle) & live_q;
    mem_req      = (state_q == StMem);
    mem_we       = mem_req & (kind_q == KindStore);
    mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_wdata    = 32'd0;
    mem_wstrb    = 4'b0000;
    if (mem_we) begin
      unique case (f3_q[1:0])
        2'b00: begin
          mem_wdata = {4{sdata_q[7:0]}};
          mem_wstrb = 4'b0001 << addr_q[1:0];
        end
        2'b01: begin
          mem_wdata = {2{sdata_q[15:0]}};
          mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata = sdata_q;
          mem_wstrb = 4'b1111;
        end
      endcase
    end
    rf_en        = (state_q == StWb) & (rd_q != 5'd0);
    rf_rd_addr   = (state_q == StWb) ? rd_q : 5'd0;
    rf_data      = (state_q == StWb) ? wb_data_q : 32'd0;
    misalign_err = misalign_q;
    timeout_err  = timeout_q;
  end

endmodule

// File: tb/tb_lsu_writeback.sv
// Directed bench for lsu_writeback with a register-write scoreboard.
module tb_lsu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd_addr;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_data;
  logic        misalign_err;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];

  lsu_writeback #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_rd_addr(in_rd_addr), .in_result(in_result),
    .in_store_data(in_store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_en(rf_en), .rf_rd_addr(rf_rd_addr), .rf_data(rf_data),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, presents one instruction for one edge.
  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) check("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    in_kind       = k;
    in_funct3     = f3;
    in_rd_addr    = rd;
    in_result     = res;
    in_store_data = sd;
    tick();
    in_valid = 1'b0;
  endtask

  // Scoreboard: every register write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rf_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rf_unexpected_write", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("rf_rd_addr", {27'd0, rf_rd_addr}, {27'd0, e[36:32]});
        check("rf_data", rf_data, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; in_valid = 1'b0; in_kind = 2'b11; in_funct3 = 3'b000; in_rd_addr = 5'd0;
    in_result = 32'd0; in_store_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    // Reset: all outputs low while held.
    tick(); tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rf_en", {31'd0, rf_en}, 32'd0);
    check("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ALU back-to-back: second held valid, accepted two cycles after the first.
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    in_valid = 1'b1; in_kind = 2'b00; in_rd_addr = 5'd5; in_result = 32'hDEADBEEF;
    tick();
    check("alu_rf_en", {31'd0, rf_en}, 32'd1);
    check("alu_ready_low", {31'd0, in_ready}, 32'd0);
    exp_q.push_back({5'd6, 32'h00000042});
    in_rd_addr = 5'd6; in_result = 32'h42;
    tick();
    check("alu_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("alu2_rf_en", {31'd0, rf_en}, 32'd1);
    tick();

    // LB / LBU at 0x1003 with ack after three MEM cycles.
    for (int sgn = 0; sgn < 2; sgn++) begin
      exp_q.push_back({5'd7, (sgn == 0) ? 32'hFFFFFF80 : 32'h00000080});
      issue(2'b01, (sgn == 0) ? 3'b000 : 3'b100, 5'd7, 32'h1003, 32'd0);
      check("lb_mem_req", {31'd0, mem_req}, 32'd1);
      check("lb_mem_addr", mem_addr, 32'h1000);
      check("lb_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("lb_we", {31'd0, mem_we}, 32'd0);
      tick(); tick();
      mem_ack = 1'b1; mem_rdata = 32'h80FF0000;
      tick();
      mem_ack = 1'b0;
      check("lb_rf_en", {31'd0, rf_en}, 32'd1);
      tick();
      check("lb_ready", {31'd0, in_ready}, 32'd1);
    end

    // SH at 0x2002, SB at 0x7001, SW at 0x7000.
    issue(2'b10, 3'b001, 5'd8, 32'h2002, 32'h1234ABCD);
    check("sh_we", {31'd0, mem_we}, 32'd1);
    check("sh_wdata", mem_wdata, 32'hABCDABCD);
    check("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
    check("sh_addr", mem_addr, 32'h2000);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_ready", {31'd0, in_ready}, 32'd1);
    issue(2'b10, 3'b000, 5'd8, 32'h7001, 32'h000000A5);
    check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_wstrb", {28'd0, mem_wstrb}, 32'h2);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    issue(2'b10, 3'b010, 5'd8, 32'h7000, 32'hCAFEF00D);
    check("sw_wdata", mem_wdata, 32'hCAFEF00D);
    check("sw_wstrb", {28'd0, mem_wstrb}, 32'hF);
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;

    // Misaligned LW and illegal load funct3.
    issue(2'b01, 3'b010, 5'd9, 32'h3001, 32'd0);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
    issue(2'b01, 3'b011, 5'd9, 32'h3000, 32'd0);
    check("ill_err", {31'd0, misalign_err}, 32'd1);
    check("ill_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Timeout with ack withheld, then a late ack ignored.
    issue(2'b01, 3'b010, 5'd10, 32'h4000, 32'd0);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("to_req_cycles", 32'(n), 32'd16);
    check("to_err", {31'd0, timeout_err}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    check("to_err_pulse", {31'd0, timeout_err}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Zero-wait load to rd=0: no write. Zero-wait LH upper half: write at N+2.
    issue(2'b01, 3'b010, 5'd0, 32'h5000, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    check("rd0_rf_en", {31'd0, rf_en}, 32'd0);
    tick();
    exp_q.push_back({5'd3, 32'hFFFF8001});
    issue(2'b01, 3'b001, 5'd3, 32'h5002, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80011234;
    tick();
    mem_ack = 1'b0;
    check("lh_rf_en", {31'd0, rf_en}, 32'd1);
    tick();

    // Reset during MEM: request drops, nothing written.
    issue(2'b01, 3'b010, 5'd4, 32'h6000, 32'd0);
    check("rstmem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    tick();
    check("rstmem_req_low", {31'd0, mem_req}, 32'd0);
    check("rstmem_ready_low", {31'd0, in_ready}, 32'd0);
    mem_ack = 1'b1;
    rst = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rstmem_ready", {31'd0, in_ready}, 32'd1);
    check("rstmem_rf_en", {31'd0, rf_en}, 32'd0);
    check("rstmem_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
    tick(); tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
